// File: rtl/eth_tx_arb.sv
// ---------------------------------------------------------------------------------------------
// eth_tx_arb: decides which of two packet sources sends the next frame through eth_tx_ctrl.
//
// One arbitration round: grant a pending requester, give eth_tx_ctrl a one-cycle start pulse,
// follow the controller's FSM through the frame, wait out the inter-frame gap, then release
// the grant and pulse Done to the requester that was served. The next round can start on the
// cycle after Done. If the controller never leaves IDLE after the start pulse, the grant is
// dropped with a Start_Err pulse and Done is not pulsed.
//
// Ports
//   Clk                in   system clock (50 MHz RMII reference)
//   Rst_n              in   asynchronous active-low reset
//   Req[1:0]           in   per-requester "complete frame queued" level
//   Tx_Ctrl_FSM_State  in   eth_tx_ctrl state, 0 = IDLE, non-zero = frame in progress
//   Eth_Pkt_Rdy        out  one-cycle start pulse to eth_tx_ctrl
//   Gnt[1:0]           out  one-hot grant, held from grant until end of IFG (FIFO mux select)
//   Done[1:0]          out  one-cycle pulse to the served requester at end of IFG
//   Busy               out  high whenever an arbitration round is in progress
//   Start_Err          out  one-cycle pulse when the controller fails to start in time
//
// Build option
//   ETH_TX_ARB_STRICT_PRIO_EN  defined: requester 0 always wins when it is requesting.
//                              undefined (default): round-robin between the two requesters.
// ---------------------------------------------------------------------------------------------
module eth_tx_arb #(
    parameter int unsigned pIFG_Cnt       = 48,
    parameter int unsigned pStart_Timeout = 16,
    parameter int unsigned pCnt_W         = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] Req,
    input  logic [3:0] Tx_Ctrl_FSM_State,
    output logic       Eth_Pkt_Rdy,
    output logic [1:0] Gnt,
    output logic [1:0] Done,
    output logic       Busy,
    output logic       Start_Err
);

    typedef enum logic [1:0] {
        StArbIdle,
        StWaitStart,
        StBusy,
        StIfg
    } state_e;

    localparam logic [pCnt_W-1:0] IfgLast   = pCnt_W'(pIFG_Cnt - 1);
    localparam logic [pCnt_W-1:0] StartLast = pCnt_W'(pStart_Timeout - 1);
    localparam logic [pCnt_W-1:0] CntMax    = {pCnt_W{1'b1}};

    state_e            state_q;
    logic [pCnt_W-1:0] cnt_q;
    logic              last_gnt_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              rdy_q;
    logic              busy_q;
    logic              err_q;

    logic              ctrl_idle;
    logic              win_idx;
    logic              cur_idx;
    logic [pCnt_W-1:0] cnt_inc;

    assign ctrl_idle = (Tx_Ctrl_FSM_State == 4'd0);
    // Gnt is one-hot while a round is active, so bit 1 is the served index.
    assign cur_idx   = gnt_q[1];
    // Saturating increment: the counter must never wrap back into a matching value.
    assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + pCnt_W'(1);

    // Winner among the current requesters; only meaningful when |Req.
    always_comb begin
        win_idx = 1'b0;
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
        win_idx = ~Req[0];
`else
        unique case (Req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_gnt_q;
            default: win_idx = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StArbIdle;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle below.
            rdy_q  <= 1'b0;
            done_q <= 2'b00;
            err_q  <= 1'b0;
            case (state_q)
                StArbIdle: begin
                    if (Req != 2'b00) begin
                        gnt_q   <= win_idx ? 2'b10 : 2'b01;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StWaitStart;
                    end
                end
                StWaitStart: begin
                    // Controller leaving IDLE wins over a timeout on the same edge.
                    if (!ctrl_idle) begin
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end else if (cnt_q == StartLast) begin
                        err_q      <= 1'b1;
                        gnt_q      <= 2'b00;
                        busy_q     <= 1'b0;
                        last_gnt_q <= cur_idx;
                        state_q    <= StArbIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StBusy: begin
                    if (ctrl_idle) begin
                        cnt_q   <= '0;
                        state_q <= StIfg;
                    end
                end
                StIfg: begin
                    if (cnt_q == IfgLast) begin
                        done_q     <= gnt_q;
                        gnt_q      <= 2'b00;
                        busy_q     <= 1'b0;
                        last_gnt_q <= cur_idx;
                        state_q    <= StArbIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= StArbIdle;
                end
            endcase
        end
    end

    assign Eth_Pkt_Rdy = rdy_q;
    assign Gnt         = gnt_q;
    assign Done        = done_q;
    assign Busy        = busy_q;
    assign Start_Err   = err_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// ---------------------------------------------------------------------------------------------
// Testbench for eth_tx_arb. A small controller model answers each start pulse with a frame of
// random length (or never starts, to force a timeout); the expected winner, Done/Start_Err
// outcome and gap timing come from the arbitration rules kept in the bench.
// ---------------------------------------------------------------------------------------------
module tb_eth_tx_arb;

    localparam int IFG = 48;
    localparam int TMO = 16;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [1:0] Req;
    logic [3:0] Tx_Ctrl_FSM_State;
    logic       Eth_Pkt_Rdy;
    logic [1:0] Gnt;
    logic [1:0] Done;
    logic       Busy;
    logic       Start_Err;

    int checks   = 0;
    int failures = 0;
    int last_ref = 1;  // index served most recently, as the rules define it

    eth_tx_arb #(
        .pIFG_Cnt      (IFG),
        .pStart_Timeout(TMO),
        .pCnt_W        (8)
    ) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .Req              (Req),
        .Tx_Ctrl_FSM_State(Tx_Ctrl_FSM_State),
        .Eth_Pkt_Rdy      (Eth_Pkt_Rdy),
        .Gnt              (Gnt),
        .Done             (Done),
        .Busy             (Busy),
        .Start_Err        (Start_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        int         rdy_lat;     // ticks from Req applied to Eth_Pkt_Rdy seen
        logic [1:0] gnt;         // Gnt when Eth_Pkt_Rdy seen
        int         rdy_extra;   // Eth_Pkt_Rdy seen again after the start pulse
        logic       gnt_stable;  // Gnt unchanged and Busy high until the end of the round
        logic [1:0] done;        // Done at the end of the round
        logic       err;         // Start_Err at the end of the round
        int         ifg;         // edges from first edge sampling controller idle to Done
        int         err_lat;     // ticks from Eth_Pkt_Rdy to Start_Err
        logic       end_clear;   // Gnt == 0 and Busy == 0 on the Done/Start_Err cycle
        logic       inv_ok;      // Gnt never 2'b11 and (Gnt != 0) == Busy
        logic       stray;       // Done/Start_Err seen while waiting for a start pulse
        logic       timed_out;   // an expected event never arrived
    } frame_obs_t;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Arbitration rule: strict build = lowest requesting index; otherwise first requesting
    // index after the last served one, going round the two requesters.
    function automatic int pick(input logic [1:0] r, input int last);
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
        for (int k = 0; k < 2; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 2; k++) if (r[(last + k) % 2]) return (last + k) % 2;
`endif
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int idx);
        return (idx == 1) ? 2'b10 : 2'b01;
    endfunction

    // Runs one arbitration round: applies req, waits for the start pulse, then plays the
    // controller (idle for dly ticks, non-zero for len ticks). Req switches to req_after at
    // tick chg_at of the round. Returns what was observed.
    task automatic frame(input logic [1:0] req, input int dly, input int len, input int chg_at,
                         input logic [1:0] req_after, output frame_obs_t o);
        int n;
        int limit;
        o            = '0;
        o.gnt_stable = 1'b1;
        o.inv_ok     = 1'b1;
        o.end_clear  = 1'b1;
        o.ifg        = -1;
        o.err_lat    = -1;
        Req          = req;
        Tx_Ctrl_FSM_State = 4'd0;
        n = 0;
        do begin
            tick();
            n++;
            if (Done != 2'b00 || Start_Err) o.stray = 1'b1;
        end while (!Eth_Pkt_Rdy && n < 8);
        o.rdy_lat = n;
        if (!Eth_Pkt_Rdy) begin
            o.timed_out = 1'b1;
            return;
        end
        o.gnt = Gnt;
        if (Gnt == 2'b11 || ((Gnt != 2'b00) != Busy)) o.inv_ok = 1'b0;
        limit = dly + len + IFG + 30;
        if (limit > 400) limit = 400;
        for (int i = 0; i < limit; i++) begin
            if (i == chg_at) Req = req_after;
            Tx_Ctrl_FSM_State = (i >= dly && i < dly + len) ? 4'($urandom_range(15, 1)) : 4'd0;
            tick();
            if (Gnt == 2'b11 || ((Gnt != 2'b00) != Busy)) o.inv_ok = 1'b0;
            if (Eth_Pkt_Rdy) o.rdy_extra++;
            if (Done != 2'b00 || Start_Err) begin
                o.done = Done;
                o.err  = Start_Err;
                if (Start_Err) o.err_lat = i + 1;
                else           o.ifg     = i - (dly + len);
                if (Gnt != 2'b00 || Busy) o.end_clear = 1'b0;
                return;
            end
            if (Gnt !== o.gnt || !Busy) o.gnt_stable = 1'b0;
        end
        o.timed_out = 1'b1;
    endtask

    task automatic test_reset();
        frame_obs_t o;
        checks++;
        if ({Eth_Pkt_Rdy, Gnt, Done, Busy, Start_Err} !== 7'd0) begin
            failures++;
            $display("FAIL reset_state: outputs=%b want 0000000",
                     {Eth_Pkt_Rdy, Gnt, Done, Busy, Start_Err});
        end
        Rst_n = 1'b1;
        Req   = 2'b00;
        repeat (5) tick();
        checks++;
        if ({Eth_Pkt_Rdy, Gnt, Busy} !== 4'd0) begin
            failures++;
            $display("FAIL idle_no_req: rdy/gnt/busy=%b want 0000", {Eth_Pkt_Rdy, Gnt, Busy});
        end
        // Run a frame into the middle of its IFG, then reset asynchronously.
        Req = 2'b01;
        tick();
        checks++;
        if ({Eth_Pkt_Rdy, Gnt} !== 3'b101) begin
            failures++;
            $display("FAIL pre_reset_grant: rdy/gnt=%b want 101", {Eth_Pkt_Rdy, Gnt});
        end
        Req = 2'b00;
        Tx_Ctrl_FSM_State = 4'd5;
        repeat (4) tick();
        Tx_Ctrl_FSM_State = 4'd0;
        repeat (21) tick();  // IFG counter now at 20
        checks++;
        if ({Gnt, Busy, Done} !== 5'b01100) begin
            failures++;
            $display("FAIL mid_ifg: gnt/busy/done=%b want 01100", {Gnt, Busy, Done});
        end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({Eth_Pkt_Rdy, Gnt, Done, Busy, Start_Err} !== 7'd0) begin
            failures++;
            $display("FAIL async_reset: outputs=%b want 0000000",
                     {Eth_Pkt_Rdy, Gnt, Done, Busy, Start_Err});
        end
        tick();
        Rst_n    = 1'b1;
        last_ref = 1;
        frame(2'b10, 1, 10, -1, 2'b00, o);
        checks++;
        if (o.rdy_lat !== 1 || o.gnt !== 2'b10) begin
            failures++;
            $display("FAIL post_reset_grant: lat=%0d gnt=%b want lat=1 gnt=10", o.rdy_lat, o.gnt);
        end
        checks++;
        if (o.done !== 2'b10 || o.ifg !== IFG) begin
            failures++;
            $display("FAIL post_reset_done: done=%b ifg=%0d want 10/%0d", o.done, o.ifg, IFG);
        end
        last_ref = 1;
    endtask

    task automatic test_single_frame();
        frame_obs_t o;
        int         idx;
        idx = pick(2'b01, last_ref);
        frame(2'b01, 2, 100, -1, 2'b00, o);
        checks++;
        if (o.rdy_lat !== 1 || o.rdy_extra !== 0) begin
            failures++;
            $display("FAIL single_rdy: lat=%0d extra=%0d want 1/0", o.rdy_lat, o.rdy_extra);
        end
        checks++;
        if (o.gnt !== onehot(idx) || o.gnt_stable !== 1'b1) begin
            failures++;
            $display("FAIL single_gnt: gnt=%b stable=%b want %b/1", o.gnt, o.gnt_stable,
                     onehot(idx));
        end
        checks++;
        if (o.done !== onehot(idx) || o.ifg !== IFG || o.err !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b ifg=%0d err=%b want %b/%0d/0", o.done, o.ifg,
                     o.err, onehot(idx), IFG);
        end
        checks++;
        if (o.end_clear !== 1'b1 || o.inv_ok !== 1'b1) begin
            failures++;
            $display("FAIL single_release: clear=%b inv=%b want 1/1", o.end_clear, o.inv_ok);
        end
        last_ref = idx;
    endtask

    task automatic test_contention();
        frame_obs_t o;
        int         idx;
        Rst_n = 1'b0;
        tick();
        Rst_n    = 1'b1;
        last_ref = 1;
        for (int f = 0; f < 4; f++) begin
            idx = pick(2'b11, last_ref);
            frame(2'b11, $urandom_range(15, 0), $urandom_range(40, 1), -1, 2'b11, o);
            checks++;
            if (o.gnt !== onehot(idx) || o.done !== onehot(idx)) begin
                failures++;
                $display("FAIL contention_order[%0d]: gnt=%b done=%b want %b", f, o.gnt, o.done,
                         onehot(idx));
            end
            checks++;
            if (o.rdy_lat !== 1 || o.ifg !== IFG || o.stray !== 1'b0) begin
                failures++;
                $display("FAIL contention_timing[%0d]: lat=%0d ifg=%0d stray=%b want 1/%0d/0", f,
                         o.rdy_lat, o.ifg, o.stray, IFG);
            end
            last_ref = idx;
        end
    endtask

    task automatic test_timeout();
        frame_obs_t o;
        int         idx;
        idx = pick(2'b01, last_ref);
        frame(2'b01, 1000, 0, 0, 2'b11, o);  // controller never starts
        checks++;
        if (o.err !== 1'b1 || o.err_lat !== TMO || o.done !== 2'b00) begin
            failures++;
            $display("FAIL timeout_err: err=%b lat=%0d done=%b want 1/%0d/00", o.err, o.err_lat,
                     o.done, TMO);
        end
        checks++;
        if (o.end_clear !== 1'b1 || o.gnt !== onehot(idx) || o.rdy_extra !== 0) begin
            failures++;
            $display("FAIL timeout_gnt: clear=%b gnt=%b extra=%0d want 1/%b/0", o.end_clear,
                     o.gnt, o.rdy_extra, onehot(idx));
        end
        last_ref = idx;
        idx = pick(2'b11, last_ref);
        frame(2'b11, 2, 5, -1, 2'b00, o);
        checks++;
        if (o.gnt !== onehot(idx) || o.rdy_lat !== 1 || o.stray !== 1'b0) begin
            failures++;
            $display("FAIL timeout_next: gnt=%b lat=%0d stray=%b want %b/1/0", o.gnt, o.rdy_lat,
                     o.stray, onehot(idx));
        end
        last_ref = idx;
    endtask

    task automatic test_late_request();
        frame_obs_t o;
        int         idx;
        idx = pick(2'b01, last_ref);
        frame(2'b01, 3, 20, 3 + 20 + 10, 2'b11, o);  // Req[1] rises 10 edges into the IFG
        checks++;
        if (o.gnt !== onehot(idx) || o.gnt_stable !== 1'b1 || o.done !== onehot(idx)) begin
            failures++;
            $display("FAIL late_hold: gnt=%b stable=%b done=%b want %b/1/%b", o.gnt,
                     o.gnt_stable, o.done, onehot(idx), onehot(idx));
        end
        last_ref = idx;
        idx = pick(2'b11, last_ref);
        frame(2'b11, 0, 8, -1, 2'b00, o);
        checks++;
        if (o.gnt !== onehot(idx) || o.rdy_lat !== 1) begin
            failures++;
            $display("FAIL late_next: gnt=%b lat=%0d want %b/1", o.gnt, o.rdy_lat, onehot(idx));
        end
        last_ref = idx;
    endtask

    task automatic test_random();
        frame_obs_t o;
        int         idx;
        int         dly;
        int         len;
        logic [1:0] req;
        logic       exp_err;
        int         act_t;
        int         exp_t;
        for (int f = 0; f < 24; f++) begin
            req     = 2'($urandom_range(3, 1));
            dly     = ($urandom_range(5, 0) == 0) ? 40 : $urandom_range(15, 0);
            len     = $urandom_range(30, 1);
            exp_err = (dly >= TMO);
            idx     = pick(req, last_ref);
            frame(req, dly, len, $urandom_range(dly + len + 40, 0), 2'($urandom_range(3, 0)), o);
            checks++;
            if (o.gnt !== onehot(idx)) begin
                failures++;
                $display("FAIL rand_gnt[%0d]: gnt=%b want %b (req=%b)", f, o.gnt, onehot(idx),
                         req);
            end
            checks++;
            if (o.done !== (exp_err ? 2'b00 : onehot(idx)) || o.err !== exp_err) begin
                failures++;
                $display("FAIL rand_end[%0d]: done=%b err=%b want %b/%b", f, o.done, o.err,
                         exp_err ? 2'b00 : onehot(idx), exp_err);
            end
            act_t = exp_err ? o.err_lat : o.ifg;
            exp_t = exp_err ? TMO : IFG;
            checks++;
            if (act_t !== exp_t) begin
                failures++;
                $display("FAIL rand_timing[%0d]: cycles=%0d want %0d", f, act_t, exp_t);
            end
            checks++;
            if ({o.rdy_lat == 1, o.rdy_extra == 0, o.gnt_stable, o.end_clear, o.inv_ok,
                 !o.stray, !o.timed_out} !== 7'b1111111) begin
                failures++;
                $display("FAIL rand_protocol[%0d]: lat=%0d extra=%0d stable=%b clear=%b inv=%b",
                         f, o.rdy_lat, o.rdy_extra, o.gnt_stable, o.end_clear, o.inv_ok);
            end
            last_ref = idx;
        end
    endtask

    initial begin
        Rst_n             = 1'b0;
        Req               = 2'b00;
        Tx_Ctrl_FSM_State = 4'd0;
        repeat (3) tick();
        test_reset();
        test_single_frame();
        test_contention();
        test_timeout();
        test_late_request();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
